axi_lite_master_q: RTL and testbench
====================================

Name: axi_lite_master_q

Overview:
Second-generation AXI4-Lite master with queued user commands. Write and read commands enter through valid/ready command ports into per-channel FIFOs of depth CMD_DEPTH. Responses leave through valid/ready response ports with backpressure. A per-channel watchdog flags a slave that stalls a transaction. The block sits between user/CSR sequencer logic and the AXI-Lite interconnect.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; multiple of 8
CMD_DEPTH, 4, per-channel command FIFO depth; power of 2, >=2
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog

Ports:
aclk  in  1  single clock
areset  in  1  reset, synchronous, active-high
wr_cmd_valid / wr_cmd_ready  in/out  1/1  write command handshake
wr_cmd_addr / wr_cmd_data / wr_cmd_strb  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  write command payload
wr_rsp_valid / wr_rsp_ready  out/in  1/1  write response handshake
wr_rsp_resp  out  2  BRESP of completed write
rd_cmd_valid / rd_cmd_ready  in/out  1/1  read command handshake
rd_cmd_addr  in  ADDR_WIDTH  read address
rd_rsp_valid / rd_rsp_ready  out/in  1/1  read response handshake
rd_rsp_data / rd_rsp_resp  out  DATA_WIDTH / 2  RDATA and RRESP
wr_timeout / rd_timeout  out  1/1  sticky watchdog flags
busy  out  1  any FIFO non-empty or any FSM not idle
awaddr, awvalid, awready; wdata, wstrb, wvalid, wready; bresp, bvalid, bready; araddr, arvalid, arready; rdata, rresp, rvalid, rready  standard AXI4-Lite master ports

Behaviour:
- Reset: synchronous; areset sampled high at an edge clears all state.
  - All valid/ready outputs to AXI and to the user are 0, except cmd_ready, which is 1 after reset.
  - Address, data and strobe outputs are 0. Response resp outputs are 0. Timeout flags are 0. busy is 0.
  - FIFOs are flushed. Reset mid-transaction drops AXI valids at that edge; the slave is reset by the system at the same time.
- Command FIFOs:
  - First-word-fall-through. cmd_ready = !full.
  - A push when full is refused. Push and pop in the same cycle are both honoured.
  - Commands issue strictly in order.
- Write FSM states:
  - W_IDLE: if the FIFO is non-empty, pop it, register addr/data/strb, go to W_XFER.
  - W_XFER: awvalid = !aw_done, wvalid = !w_done. The aw_done and w_done flags are set on their handshakes, in either order or the same cycle. Go to W_RESP once both are done.
  - W_RESP: bready = 1. On bvalid, capture bresp and go to W_OUT.
  - W_OUT: wr_rsp_valid = 1. On wr_rsp_ready, go to W_IDLE.
- Read FSM states:
  - R_IDLE: pop the FIFO, register the address, go to R_ADDR.
  - R_ADDR: arvalid = 1. On arready, go to R_DATA.
  - R_DATA: rready = 1. On rvalid, capture rdata/rresp and go to R_OUT.
  - R_OUT: rd_rsp_valid = 1. On rd_rsp_ready, go to R_IDLE.
- Latency: a command handshake at edge N into an idle channel with an empty FIFO gives AW/W/AR valid high after edge N+1. A B/R handshake at edge M gives rsp_valid high after edge M.
- Valid rules: valids never depend combinationally on ready, and are held until their handshake. Payloads are stable while valid.
- bready and rready are never high in OUT states, so no AXI response can be lost.
- Write and read channels are fully independent; simultaneous activity is allowed.
- Watchdog, per channel:
  - The counter runs in XFER/RESP (write) or ADDR/DATA (read) and resets to 0 on entering IDLE. It saturates.
  - On reaching TIMEOUT_CYCLES the channel's timeout flag sets. The flag is sticky until areset.
  - The watchdog never aborts a transaction, since aborting is AXI-illegal. TIMEOUT_CYCLES=0 holds both flags at 0.
- busy is combinational: FIFO non-empty OR FSM not idle, per channel, ORed.

Decomposition:
- Package axi_lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - write and read FSM state encodings;
  - the command-word field offsets.
- Sub-module axi_lite_cmd_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty. It is instantiated twice: write command word {addr,data,strb} and read command word {addr}.

Test Plan:
- Single write 0x10 / 0xDEADBEEF / strb 0xF, slave with awready=wready=1 and bvalid one cycle later with OKAY → awvalid high 2 cycles after the command; wr_rsp_valid with resp 2'b00; busy returns to 0.
- Write with wready three cycles before awready → wvalid drops after its handshake, awvalid is held until awready; exactly one AW and one W are seen.
- Push 5 reads with CMD_DEPTH=4 while the slave stalls arready → wr_cmd_ready unaffected; rd_cmd_ready=0 after the 4th queued entry; all 5 complete in address order 0x0,0x4,0x8,0xC,0x10 once released.
- rd_rsp_ready held 0 for 10 cycles → rready stays 0 and rvalid is not accepted; rd_rsp_data stays stable at 0xCAFEF00D with SLVERR until accepted.
- TIMEOUT_CYCLES=16, bvalid withheld 20 cycles → wr_timeout rises on the 16th cycle of the wait and stays 1 after the response completes; rd_timeout stays 0.
- areset asserted during W_XFER with 2 queued commands → next cycle all valids are 0, busy=0 and wr_cmd_ready=1; no stale command is issued afterwards.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the queued AXI4-Lite master: response codes,
// channel FSM encodings and command-word field layout.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_OUT} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_OUT} rd_state_e;

  // Write command word is {addr, data, strb}, strobe in the LSBs.
  localparam int WCMD_STRB_LSB = 0;
  localparam int RCMD_ADDR_LSB = 0;

  function automatic int wcmd_data_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int wcmd_addr_lsb(input int dw);
    return dw / 8 + dw;
  endfunction

  function automatic int wcmd_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/axi_lite_cmd_fifo.sv
// First-word-fall-through command FIFO; dout shows the head entry whenever
// empty is low. Full pushes and empty pops are ignored.
module axi_lite_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_lite_master_q.sv
// AXI4-Lite master with queued write/read commands, backpressured responses
// and a sticky per-channel stall watchdog. Write and read run independently.
module axi_lite_master_q
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    wr_cmd_valid,
  output logic                    wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   wr_cmd_data,
  input  logic [DATA_WIDTH/8-1:0] wr_cmd_strb,
  output logic                    wr_rsp_valid,
  input  logic                    wr_rsp_ready,
  output logic [1:0]              wr_rsp_resp,
  input  logic                    rd_cmd_valid,
  output logic                    rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_cmd_addr,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic [1:0]              rd_rsp_resp,
  output logic                    wr_timeout,
  output logic                    rd_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int SW     = DATA_WIDTH / 8;
  localparam int WCW    = wcmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int WD_LSB = wcmd_data_lsb(DATA_WIDTH);
  localparam int WA_LSB = wcmd_addr_lsb(DATA_WIDTH);
  localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
  localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);

  // Saturating stall counter; cleared whenever the channel heads back to idle.
  function automatic logic [TW-1:0] wd_next(input logic [TW-1:0] c,
                                            input logic run, input logic clr);
    if (clr) return '0;
    if (run && c != TO_LIM) return c + TW'(1);
    return c;
  endfunction

  logic [WCW-1:0]        wf_dout;
  logic                  wf_full, wf_empty, wf_pop;
  logic [ADDR_WIDTH-1:0] rf_dout;
  logic                  rf_full, rf_empty, rf_pop;

  axi_lite_cmd_fifo #(.WIDTH(WCW), .DEPTH(CMD_DEPTH)) u_wr_fifo (
    .clk(aclk), .rst(areset), .push(wr_cmd_valid),
    .din({wr_cmd_addr, wr_cmd_data, wr_cmd_strb}),
    .pop(wf_pop), .dout(wf_dout), .full(wf_full), .empty(wf_empty)
  );

  axi_lite_cmd_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(CMD_DEPTH)) u_rd_fifo (
    .clk(aclk), .rst(areset), .push(rd_cmd_valid), .din(rd_cmd_addr),
    .pop(rf_pop), .dout(rf_dout), .full(rf_full), .empty(rf_empty)
  );

  wr_state_e             wst_q, wst_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [TW-1:0]         wcnt_q, wcnt_d;
  logic                  wr_to_q, wr_to_d;

  rd_state_e             rst_q, rst_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [TW-1:0]         rcnt_q, rcnt_d;
  logic                  rd_to_q, rd_to_d;

  assign wr_cmd_ready = !wf_full;
  assign rd_cmd_ready = !rf_full;
  assign awaddr       = awaddr_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign awvalid      = (wst_q == W_XFER) && !aw_done_q;
  assign wvalid       = (wst_q == W_XFER) && !w_done_q;
  assign bready       = (wst_q == W_RESP);
  assign wr_rsp_valid = (wst_q == W_OUT);
  assign wr_rsp_resp  = bresp_q;
  assign araddr       = araddr_q;
  assign arvalid      = (rst_q == R_ADDR);
  assign rready       = (rst_q == R_DATA);
  assign rd_rsp_valid = (rst_q == R_OUT);
  assign rd_rsp_data  = rdata_q;
  assign rd_rsp_resp  = rresp_q;
  assign wr_timeout   = wr_to_q;
  assign rd_timeout   = rd_to_q;
  assign busy = !wf_empty || (wst_q != W_IDLE) || !rf_empty || (rst_q != R_IDLE);

  always_comb begin
    wst_d     = wst_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bresp_d   = bresp_q;
    wf_pop    = 1'b0;
    case (wst_q)
      W_IDLE: if (!wf_empty) begin
        wf_pop    = 1'b1;
        awaddr_d  = wf_dout[WA_LSB +: ADDR_WIDTH];
        wdata_d   = wf_dout[WD_LSB +: DATA_WIDTH];
        wstrb_d   = wf_dout[WCMD_STRB_LSB +: SW];
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        wst_d     = W_XFER;
      end
      W_XFER: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) wst_d = W_RESP;
      end
      W_RESP: if (bvalid) begin
        bresp_d = bresp;
        wst_d   = W_OUT;
      end
      W_OUT: if (wr_rsp_ready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
    wcnt_d  = wd_next(wcnt_q, (wst_q == W_XFER) || (wst_q == W_RESP), wst_d == W_IDLE);
    wr_to_d = wr_to_q | (WD_EN && (wcnt_d == TO_LIM));
  end

  always_comb begin
    rst_d    = rst_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rf_pop   = 1'b0;
    case (rst_q)
      R_IDLE: if (!rf_empty) begin
        rf_pop   = 1'b1;
        araddr_d = rf_dout[RCMD_ADDR_LSB +: ADDR_WIDTH];
        rst_d    = R_ADDR;
      end
      R_ADDR: if (arready) rst_d = R_DATA;
      R_DATA: if (rvalid) begin
        rdata_d = rdata;
        rresp_d = rresp;
        rst_d   = R_OUT;
      end
      R_OUT: if (rd_rsp_ready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
    rcnt_d  = wd_next(rcnt_q, (rst_q == R_ADDR) || (rst_q == R_DATA), rst_d == R_IDLE);
    rd_to_d = rd_to_q | (WD_EN && (rcnt_d == TO_LIM));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wst_q     <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wcnt_q    <= '0;
      wr_to_q   <= 1'b0;
      rst_q     <= R_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rcnt_q    <= '0;
      rd_to_q   <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bresp_q   <= bresp_d;
      wcnt_q    <= wcnt_d;
      wr_to_q   <= wr_to_d;
      rst_q     <= rst_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rcnt_q    <= rcnt_d;
      rd_to_q   <= rd_to_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master_q.sv
// Directed bench for axi_lite_master_q: hand-driven AXI slave, hand-computed
// expectations, immediate assertions at each comparison.
module tb_axi_lite_master_q;

  logic        aclk = 1'b0;
  logic        areset;
  logic        wr_cmd_valid, wr_cmd_ready;
  logic [31:0] wr_cmd_addr, wr_cmd_data;
  logic [3:0]  wr_cmd_strb;
  logic        wr_rsp_valid, wr_rsp_ready;
  logic [1:0]  wr_rsp_resp;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [31:0] rd_cmd_addr;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [31:0] rd_rsp_data;
  logic [1:0]  rd_rsp_resp;
  logic        wr_timeout, rd_timeout, busy;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int passed = 0;
  int total  = 0;
  int aw_cnt = 0, w_cnt = 0, r_cnt = 0, ar_cnt = 0, rr_cnt = 0;
  logic [31:0] ar_addr [16];
  int base_a, base_b;

  axi_lite_master_q #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data), .wr_cmd_strb(wr_cmd_strb),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_resp(wr_rsp_resp),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_resp(rd_rsp_resp),
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout), .busy(busy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (!areset) begin
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
      if (rvalid && rready)   r_cnt  <= r_cnt + 1;
      if (rd_rsp_valid && rd_rsp_ready) rr_cnt <= rr_cnt + 1;
      if (arvalid && arready) begin
        if (ar_cnt < 16) ar_addr[ar_cnt] <= araddr;
        ar_cnt <= ar_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    areset = 1'b1;
    wr_cmd_valid = 0; wr_cmd_addr = 0; wr_cmd_data = 0; wr_cmd_strb = 0;
    wr_rsp_ready = 0; rd_cmd_valid = 0; rd_cmd_addr = 0; rd_rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    tick(); tick();
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, wr_rsp_valid, rd_rsp_valid}), 64'd0);
    chk("rst_cmd_ready", 64'({wr_cmd_ready, rd_cmd_ready}), 64'd3);
    chk("rst_busy_to", 64'({busy, wr_timeout, rd_timeout}), 64'd0);
    chk("rst_payload", 64'({awaddr, wdata}), 64'd0);
    chk("rst_resp", 64'({wr_rsp_resp, rd_rsp_resp, wstrb, araddr}), 64'd0);
    areset = 1'b0;
    tick();

    // single write, always-ready slave
    awready = 1; wready = 1;
    wr_cmd_valid = 1; wr_cmd_addr = 32'h10; wr_cmd_data = 32'hDEADBEEF; wr_cmd_strb = 4'hF;
    tick();
    wr_cmd_valid = 0;
    chk("w1_aw_not_yet", 64'(awvalid), 64'd0);
    chk("w1_busy", 64'(busy), 64'd1);
    tick();
    chk("w1_valids", 64'({awvalid, wvalid}), 64'd3);
    chk("w1_payload", 64'({awaddr, wdata}), {32'h10, 32'hDEADBEEF});
    chk("w1_strb", 64'(wstrb), 64'hF);
    tick();
    chk("w1_resp_phase", 64'({awvalid, wvalid, bready}), 64'b001);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("w1_rsp", 64'({wr_rsp_valid, wr_rsp_resp, bready}), 64'b1000);
    wr_rsp_ready = 1;
    tick();
    wr_rsp_ready = 0;
    chk("w1_done", 64'({wr_rsp_valid, busy}), 64'd0);
    chk("w1_counts", 64'({aw_cnt[7:0], w_cnt[7:0]}), 64'h0101);

    // W accepted three cycles before AW
    awready = 0; wready = 1;
    wr_cmd_valid = 1; wr_cmd_addr = 32'h20; wr_cmd_data = 32'h11223344; wr_cmd_strb = 4'h3;
    tick();
    wr_cmd_valid = 0;
    tick();
    chk("w2_valids", 64'({awvalid, wvalid}), 64'd3);
    tick();
    chk("w2_w_dropped", 64'({awvalid, wvalid}), 64'b10);
    tick(); tick();
    chk("w2_aw_held", 64'({awvalid, wvalid, awaddr}), {2'b10, 32'h20});
    awready = 1;
    tick();
    chk("w2_resp_phase", 64'({awvalid, bready}), 64'b01);
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0;
    chk("w2_rsp", 64'({wr_rsp_valid, wr_rsp_resp}), 64'b110);
    wr_rsp_ready = 1;
    tick();
    wr_rsp_ready = 0;
    chk("w2_counts", 64'({aw_cnt[7:0], w_cnt[7:0]}), 64'h0202);

    // watchdog: bvalid withheld past 16 cycles
    wr_cmd_valid = 1; wr_cmd_addr = 32'h30; wr_cmd_data = 32'h0; wr_cmd_strb = 4'h1;
    tick();
    wr_cmd_valid = 0;
    tick();
    repeat (15) tick();
    chk("to_before", 64'(wr_timeout), 64'd0);
    tick();
    chk("to_set", 64'({wr_timeout, rd_timeout}), 64'b10);
    repeat (4) tick();
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0; wr_rsp_ready = 1;
    tick();
    wr_rsp_ready = 0;
    chk("to_sticky", 64'({wr_timeout, rd_timeout, busy}), 64'b100);

    // reset in W_XFER with two commands still queued
    awready = 0; wready = 0;
    wr_cmd_valid = 1; wr_cmd_addr = 32'h40;
    tick();
    wr_cmd_addr = 32'h44;
    tick();
    wr_cmd_addr = 32'h48;
    tick();
    wr_cmd_valid = 0;
    chk("rst2_pre", 64'({awvalid, busy, awaddr}), {2'b11, 32'h40});
    base_a = aw_cnt;
    areset = 1;
    tick();
    areset = 0;
    chk("rst2_valids", 64'({awvalid, wvalid, arvalid, bready, rready, wr_rsp_valid, rd_rsp_valid}), 64'd0);
    chk("rst2_state", 64'({busy, wr_cmd_ready, wr_timeout}), 64'b010);
    awready = 1; wready = 1;
    repeat (6) tick();
    chk("rst2_no_stale", 64'({awvalid, busy}), 64'd0);
    chk("rst2_aw_count", 64'(aw_cnt - base_a), 64'd0);

    // five reads queued behind a stalled arready
    arready = 0;
    base_a = ar_cnt; base_b = rr_cnt;
    for (int i = 0; i < 5; i++) begin
      rd_cmd_valid = 1; rd_cmd_addr = 32'(i * 4);
      chk("rq_ready_open", 64'(rd_cmd_ready), 64'd1);
      tick();
    end
    rd_cmd_valid = 0;
    chk("rq_full", 64'({rd_cmd_ready, wr_cmd_ready}), 64'b01);
    tick(); tick();
    chk("rq_stall", 64'({arvalid, araddr}), {1'b1, 32'h0});
    arready = 1; rvalid = 1; rdata = 32'h5A5A0000; rresp = 2'b00; rd_rsp_ready = 1;
    for (int k = 0; k < 60 && (rr_cnt - base_b) < 5; k++) tick();
    rvalid = 0; rd_rsp_ready = 0;
    chk("rq_completed", 64'(rr_cnt - base_b), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("rq_order", 64'(ar_addr[base_a + i]), 64'(i * 4));
    chk("rq_idle", 64'({busy, rd_timeout}), 64'd0);

    // response held back by rd_rsp_ready
    base_b = r_cnt;
    rd_cmd_valid = 1; rd_cmd_addr = 32'h40;
    tick();
    rd_cmd_valid = 0;
    tick();
    chk("bp_ar", 64'({arvalid, araddr}), {1'b1, 32'h40});
    tick();
    chk("bp_rready", 64'(rready), 64'd1);
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
    tick();
    rdata = 32'h12345678; rresp = 2'b00;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 64'({rready, rd_rsp_valid, rd_rsp_resp, rd_rsp_data}),
          {30'd0, 1'b0, 1'b1, 2'b10, 32'hCAFEF00D});
      tick();
    end
    rvalid = 0; rd_rsp_ready = 1;
    tick();
    rd_rsp_ready = 0;
    chk("bp_done", 64'({rd_rsp_valid, busy}), 64'd0);
    chk("bp_one_r", 64'(r_cnt - base_b), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
